// File: rtl/bc_clr_skid_buf.sv
// Two-entry valid/ready register slice with a synchronous clear.
// The main entry M always drives oDat, and the skid entry S absorbs one extra
// beat, so oReady can be a registered signal with no combinational path from
// iReady. Beats leave in strict FIFO order. A clear reloads both entries with
// INI_DATA and drops any push in the same cycle.
module bc_clr_skid_buf #(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  INI_DATA = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iClr,
  input  logic             iValid,
  input  logic [WIDTH-1:0] iDat,
  output logic             oReady,
  output logic             oValid,
  output logic [WIDTH-1:0] oDat,
  input  logic             iReady,
  output logic [1:0]       oCnt
);

  // The encoding equals the occupancy, so oCnt is the state register itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             push, pop;

  // Every output is decoded from flops only. No input reaches an output without
  // first passing through a register.
  assign oValid = (state_q != EMPTY);
  assign oReady = (state_q != TWO);
  assign oCnt   = state_q;
  assign oDat   = m_q;

  assign push = iValid & oReady;
  assign pop  = oValid & iReady;

  // Next-state and entry updates. A clear overrides every handshake.
  always_comb begin
    // NOTE: every variable gets a default before any branch. Otherwise a path
    // that skips an assignment would infer a latch.
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (iClr) begin
      state_d = EMPTY;
      m_d     = INI_DATA;
      s_d     = INI_DATA;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            m_d     = iDat;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            m_d = iDat;                 // consumer takes M, new beat replaces it
          end else if (push) begin
            s_d     = iDat;             // consumer stalled, park beat in skid
            state_d = TWO;
          end else if (pop) begin
            state_d = EMPTY;            // M keeps the popped value
          end
        end
        TWO: begin
          if (pop) begin
            m_d     = s_q;              // older beat leaves first, skid moves up
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          m_d     = INI_DATA;
          s_d     = INI_DATA;
        end
      endcase
    end
  end

  // State and storage registers, with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: both data entries are reset, not only the state. oDat must show
    // INI_DATA after reset, and S must be reloaded so it never holds stale data.
    if (!rst) begin
      state_q <= EMPTY;
      m_q     <= INI_DATA;
      s_q     <= INI_DATA;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // register samples pre-edge values.
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

endmodule

// File: tb/tb_bc_clr_skid_buf.sv
// Self-checking bench for bc_clr_skid_buf.
// A queue-based model predicts the outputs, and one negedge process compares
// the DUT against it every cycle. Directed scenarios add literal expectations
// that pin the model, then a random soak runs.
module tb_bc_clr_skid_buf;

  localparam int unsigned WIDTH = 32;
  localparam logic [31:0] INI   = 32'h1;

  logic             clk;
  logic             rst;
  logic             iClr;
  logic             iValid;
  logic [WIDTH-1:0] iDat;
  logic             oReady;
  logic             oValid;
  logic [WIDTH-1:0] oDat;
  logic             iReady;
  logic [1:0]       oCnt;

  int total = 0;
  int bad   = 0;

  bc_clr_skid_buf #(.WIDTH(WIDTH), .INI_DATA(INI)) dut (
    .clk    (clk),
    .rst    (rst),
    .iClr   (iClr),
    .iValid (iValid),
    .iDat   (iDat),
    .oReady (oReady),
    .oValid (oValid),
    .oDat   (oDat),
    .iReady (iReady),
    .oCnt   (oCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the queue holds the beats in flight, and m_last is what oDat shows
  // when the queue is empty.
  logic [31:0] mq[$];
  logic [31:0] m_last = INI;
  bit          chk_en = 1'b0;
  bit          stall_chk = 1'b0;
  logic [31:0] stall_dat;

  function automatic logic [31:0] exp_dat();
    return (mq.size() != 0) ? mq[0] : m_last;
  endfunction

  // Model update on each active edge. It uses the same input values the DUT samples.
  always @(posedge clk) begin
    bit do_pop, do_push;
    stall_chk = 1'b0;
    if (!rst || iClr) begin
      mq.delete();
      m_last = INI;
    end else begin
      do_pop  = (mq.size() != 0) && iReady;
      do_push = iValid && (mq.size() < 2);
      if ((mq.size() != 0) && !iReady) begin
        stall_chk = 1'b1;
        stall_dat = exp_dat();
      end
      if (do_pop)  m_last = mq.pop_front();
      if (do_push) mq.push_back(iDat);
    end
  end

  // Compare DUT outputs with the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("oValid", {31'b0, oValid}, {31'b0, mq.size() != 0});
      check("oReady", {31'b0, oReady}, {31'b0, mq.size() < 2});
      check("oCnt",   {30'b0, oCnt},   32'(mq.size()));
      check("oDat",   oDat,            exp_dat());
      if (stall_chk) begin
        check("stall_oDat",   oDat,            stall_dat);
        check("stall_oValid", {31'b0, oValid}, 32'h1);
      end
    end
  end

  // Apply one cycle of inputs just after a negedge, then return at the next
  // negedge, where the outputs reflect that edge.
  task automatic cyc(input bit r_n, input bit clr, input bit v, input logic [31:0] d, input bit rdy);
    #1;
    rst    = r_n;
    iClr   = clr;
    iValid = v;
    iDat   = d;
    iReady = rdy;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; iClr = 1'b0; iValid = 1'b0; iDat = '0; iReady = 1'b0;
    @(negedge clk);

    // Reset held for two cycles, then released.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_oValid", {31'b0, oValid}, 32'h0);
    check("rst_oReady", {31'b0, oReady}, 32'h1);
    check("rst_oCnt",   {30'b0, oCnt},   32'h0);
    check("rst_oDat",   oDat,            32'h1);

    // Streaming at full throughput.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 32'hA0 + 32'(i), 1'b1);
      check("stream_oDat",   oDat,            32'hA0 + 32'(i));
      check("stream_oCnt",   {30'b0, oCnt},   32'h1);
      check("stream_oReady", {31'b0, oReady}, 32'h1);
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("drain_oCnt", {30'b0, oCnt}, 32'h0);
    check("drain_oDat", oDat,          32'hA7);

    // Backpressure fills both entries. A third beat waits until space opens.
    cyc(1'b1, 1'b0, 1'b1, 32'h11, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 32'h22, 1'b0);
    check("bp_oCnt",   {30'b0, oCnt},   32'h2);
    check("bp_oReady", {31'b0, oReady}, 32'h0);
    check("bp_oDat",   oDat,            32'h11);
    cyc(1'b1, 1'b0, 1'b1, 32'h33, 1'b0);
    check("bp_hold_oCnt", {30'b0, oCnt}, 32'h2);
    check("bp_hold_oDat", oDat,          32'h11);
    cyc(1'b1, 1'b0, 1'b1, 32'h33, 1'b1);
    check("bp_pop1_oDat", oDat,          32'h22);
    check("bp_pop1_oCnt", {30'b0, oCnt}, 32'h1);
    cyc(1'b1, 1'b0, 1'b1, 32'h33, 1'b1);
    check("bp_pop2_oDat", oDat,          32'h33);
    check("bp_pop2_oCnt", {30'b0, oCnt}, 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("bp_empty_oCnt", {30'b0, oCnt}, 32'h0);

    // Clear while full, with a push in the same cycle that must be dropped.
    cyc(1'b1, 1'b0, 1'b1, 32'h11, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 32'h22, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'h44, 1'b0);
    check("clr_oCnt",   {30'b0, oCnt},   32'h0);
    check("clr_oValid", {31'b0, oValid}, 32'h0);
    check("clr_oReady", {31'b0, oReady}, 32'h1);
    check("clr_oDat",   oDat,            32'h1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("clr_after_oDat", oDat, 32'h1);

    // Simultaneous push and pop while holding one beat.
    cyc(1'b1, 1'b0, 1'b1, 32'h5, 1'b0);
    check("pp_load_oDat", oDat, 32'h5);
    cyc(1'b1, 1'b0, 1'b1, 32'h6, 1'b1);
    check("pp_oDat", oDat,          32'h6);
    check("pp_oCnt", {30'b0, oCnt}, 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // A reset in mid-stream discards held beats.
    cyc(1'b1, 1'b0, 1'b1, 32'h77, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h88, 1'b1);
    check("mrst_oCnt", {30'b0, oCnt}, 32'h0);
    check("mrst_oDat", oDat,          32'h1);

    // Random soak with occasional clears.
    for (int i = 0; i < 500; i++) begin
      cyc(1'b1, ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
          $urandom, 1'($urandom_range(0, 1)));
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bc_clr_skid_buf.md
Name: bc_clr_skid_buf

Overview:
- Two-entry valid/ready register slice with synchronous clear-to-initial-value.
- Sits between a producer and a consumer that can stall. It supplies the backpressure and read-side handshake for the team's clear/enable register style, replacing a bare enable with a ready/valid pair.
- Breaks the combinational ready path: oReady is a registered signal. Data ordering is strict FIFO, and no beat is lost or duplicated except on clear.

Parameters:
WIDTH, 32, data width of iDat/oDat and of both storage entries
INI_DATA, 32'h1, value loaded into the main entry (visible on oDat) at reset and on clear; width WIDTH

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low; clock clk
iClr  input  1  synchronous flush; priority over all handshakes
iValid  input  1  upstream beat valid
iDat  input  WIDTH  upstream beat data
oReady  output  1  upstream may transfer (registered)
oValid  output  1  downstream beat valid
oDat  output  WIDTH  downstream beat data (main entry)
iReady  input  1  downstream accepts beat
oCnt  output  2  occupancy, 0..2

Behaviour:
- Upstream push = iValid & oReady. Downstream pop = oValid & iReady. Both are sampled at the rising edge of clk.
- Storage: main entry M, which drives oDat, and skid entry S. State is EMPTY (oCnt=0), ONE (oCnt=1) or TWO (oCnt=2).
- All outputs are registered: oValid = (state!=EMPTY), oReady = (state!=TWO), oCnt = state encoding.
- Reset (rst==0 at edge):
  - state=EMPTY, M=INI_DATA, S=INI_DATA.
  - oValid=0, oReady=1, oCnt=0, oDat=INI_DATA.
  - rst has priority over iClr and all handshakes. A reset mid-stream discards all held beats.
- Clear (rst==1, iClr==1): same register values as reset.
  - A push presented in the same cycle is dropped.
  - A pop in the same cycle is still counted as taken by the downstream, because oValid/oDat were already presented.
- Transitions (rst==1, iClr==0):
  - EMPTY: push -> M<=iDat, ONE. Otherwise stay. oDat keeps its last value.
  - ONE:
    - push & pop -> M<=iDat, stay ONE (full throughput).
    - push only -> S<=iDat, TWO.
    - pop only -> EMPTY, M unchanged.
    - neither -> stay.
  - TWO: oReady=0, so no push is possible and iValid is ignored.
    - pop -> M<=S, ONE.
    - no pop -> stay, M/S stable.
- Latency: a beat pushed at edge N is on oDat with oValid=1 after edge N, i.e. poppable at edge N+1. The minimum is 1 cycle. With no stalls, sustained throughput is 1 beat/cycle.
- Stall rule: while oValid=1 and iReady=0, oDat and oValid stay stable, with no change until the pop.
- Ordering: beats leave in push order. The M<=S move preserves order.
- oDat when EMPTY holds the last popped value, or INI_DATA after reset/clear. The consumer must not use it.
- No combinational path from iReady or iValid to any output.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> oValid=0, oReady=1, oCnt=0, oDat=32'h1 at the first cycle after release.
- Streaming: iReady=1, push 32'hA0..32'hA7 on consecutive cycles -> oDat shows A0..A7 on consecutive cycles, each beat 1 cycle after its push; oReady stays 1; oCnt stays 1 during the stream.
- Backpressure: iReady=0, push 32'h11 then 32'h22 -> oCnt=2, oReady=0, oDat=32'h11. A third iValid with 32'h33 is not accepted. Set iReady=1 -> pops 11, then 22, then the producer's 33 is accepted; order is 11, 22, 33.
- Clear while full: TWO holding 11/22, assert iClr with iValid=1 (iDat=32'h44) -> next cycle oCnt=0, oValid=0, oReady=1, oDat=32'h1; 44 is never output.
- Simultaneous push/pop in ONE: M=32'h5, push 32'h6 with iReady=1 -> 5 is popped, oDat=6, oCnt stays 1.
- Random soak (~500 cycles): random iValid/iReady/iClr, with a scoreboard model of the same rules -> no loss, duplication or reordering between clears; oDat stable whenever oValid & !iReady.
